// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : reg_arb_pkg
//  Brief   : Shared state encoding and default sizes for reg_write_arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int c_DEF_NREQ = 2;
    localparam int c_DEF_NREG = 4;
    localparam int c_DEF_W    = 8;

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : reg_write_arbiter_if
//  Brief   : Requester handshake and register-bank bus of the write arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int NREG = c_DEF_NREG,
    parameter int W    = c_DEF_W
) ();
    localparam int AW = $clog2(NREG);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*W-1:0]  wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [NREG-1:0]    reg_le;
    logic [W-1:0]       reg_d;
    logic               busy;
    logic               err;

    modport master (
        output req, addr, wdata,
        input  gnt, ack, reg_le, reg_d, busy, err
    );

    modport slave (
        input  req, addr, wdata,
        output gnt, ack, reg_le, reg_d, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module  : rr_picker
//  Brief   : Combinational round-robin pick: rotate by ptr, find first, un-rotate.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_picker
    import reg_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IW-1:0]   i_ptr,
    output logic                 o_valid,
    output logic [IW-1:0]        o_win
);
    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;

    // w_rot[0] is the requester currently holding priority
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = i_req[(i + int'(i_ptr)) % NREQ];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_win   = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
    assign o_valid = |i_req;
endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : reg_write_arbiter
//  Brief   : Round-robin serialising write arbiter for a latch register bank.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int NREG = c_DEF_NREG,
    parameter int W    = c_DEF_W
) (
    input  wire logic           clk,
    input  wire logic           R,
    reg_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int IW = $clog2(NREQ);

    arb_state_t       r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    r_win, w_win_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]  r_ack, w_ack_nxt;
    logic [NREG-1:0]  r_le;
    logic [W-1:0]     r_d, w_d_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_err, w_err_nxt;

    logic             w_valid;
    logic [IW-1:0]    w_win;
    logic [AW-1:0]    w_sel_addr;
    logic [W-1:0]     w_sel_data;
    logic             w_addr_ok;
    logic             w_le_set;
    logic [NREG-1:0]  w_le_hit;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_win   (w_win)
    );

    assign w_sel_addr = bus.addr[int'(w_win)*AW +: AW];
    assign w_sel_data = bus.wdata[int'(w_win)*W +: W];
    assign w_addr_ok  = ({1'b0, w_sel_addr} < (AW+1)'(NREG));
    assign w_le_set   = (r_state == IDLE) && w_valid && w_addr_ok;

    for (genvar k = 0; k < NREG; k++) begin : g_le_dec
        assign w_le_hit[k] = (w_sel_addr == AW'(k));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = r_ack;
        w_d_nxt     = r_d;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = LOAD;
                    w_win_nxt   = w_win;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_busy_nxt  = 1'b1;
                    w_d_nxt     = w_sel_data;
                    w_err_nxt   = !w_addr_ok;
                end
            end
            LOAD: begin
                w_state_nxt = ACK;
                w_gnt_nxt   = '0;
                w_err_nxt   = 1'b0;
                w_ack_nxt   = NREQ'(1) << r_win;
            end
            ACK: begin
                if (!bus.req[r_win]) begin
                    w_state_nxt = IDLE;
                    w_ack_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // reg_le is only high in LOAD; every other transition clears it
    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_le    <= '0;
            r_d     <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_le    <= w_le_set ? w_le_hit : '0;
            r_d     <= w_d_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.ack    = r_ack;
    assign bus.reg_le = r_le;
    assign bus.reg_d  = r_d;
    assign bus.busy   = r_busy;
    assign bus.err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_reg_write_arbiter
//  Brief   : Directed and randomised checks of reg_write_arbiter against a
//            transaction-level model and a behavioural latch bank.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int NREQ   = 2;
    localparam int NREG   = 4;
    localparam int W      = 8;
    localparam int AW     = 2;
    localparam int NREG_B = 3;

    logic clk = 1'b0;
    logic R;
    logic R_b;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG),   .W(W)) bus_a ();
    reg_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG_B), .W(W)) bus_b ();

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W)) u_dut_a (
        .clk (clk),
        .R   (R),
        .bus (bus_a)
    );

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG_B), .W(W)) u_dut_b (
        .clk (clk),
        .R   (R_b),
        .bus (bus_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural latch bank: transparent while reg_le is high, captured mid-cycle
    logic [W-1:0] dbank   [NREG];
    logic [W-1:0] exp_bank[NREG];
    always @(negedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (bus_a.reg_le[k] === 1'b1) dbank[k] <= bus_a.reg_d;
        end
    end

    // Transaction-level reference: phase 0 waiting, 1 writing, 2 acknowledging
    int              m_phase, m_ptr, m_win;
    logic [NREQ-1:0] e_gnt, e_ack;
    logic [NREG-1:0] e_le;
    logic [W-1:0]    e_d;
    logic            e_busy, e_err;

    task automatic model_step(input logic rst);
        int w;
        int a;
        w = -1;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_win = 0;
            e_gnt = '0; e_ack = '0; e_le = '0; e_d = '0; e_busy = 1'b0; e_err = 1'b0;
        end else if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && bus_a.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                m_win   = w;
                m_phase = 1;
                a       = int'(bus_a.addr[w*AW +: AW]);
                e_gnt   = NREQ'(1 << w);
                e_busy  = 1'b1;
                e_d     = bus_a.wdata[w*W +: W];
                e_err   = (a >= NREG);
                e_le    = (a < NREG) ? NREG'(1 << a) : '0;
                if (a < NREG) exp_bank[a] = e_d;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            e_gnt = '0; e_le = '0; e_err = 1'b0;
            e_ack = NREQ'(1 << m_win);
        end else if (!bus_a.req[m_win]) begin
            m_phase = 0;
            e_ack   = '0;
            e_busy  = 1'b0;
            m_ptr   = (m_win + 1) % NREQ;
        end
    endtask

    // One clock of instance A: model update, output compare, then bank compare
    task automatic tick();
        @(posedge clk);
        model_step(R);
        #1;
        check("gnt",    bus_a.gnt,    e_gnt);
        check("ack",    bus_a.ack,    e_ack);
        check("reg_le", bus_a.reg_le, e_le);
        check("reg_d",  bus_a.reg_d,  e_d);
        check("busy",   bus_a.busy,   e_busy);
        check("err",    bus_a.err,    e_err);
        @(negedge clk);
        #1;
        check("bank", {dbank[3], dbank[2], dbank[1], dbank[0]},
                      {exp_bank[3], exp_bank[2], exp_bank[1], exp_bank[0]});
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    int grant_log[$];
    int ack_cycles;

    initial begin
        for (int k = 0; k < NREG; k++) begin
            dbank[k]    = '0;
            exp_bank[k] = '0;
        end
        model_step(1'b1);
        R = 1'b1; R_b = 1'b1;
        bus_a.req = 2'b11; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 2'b00; bus_b.addr = '0; bus_b.wdata = '0;

        // Reset held with both requests pending
        tick();
        tick();
        R = 1'b0; R_b = 1'b0;
        bus_a.req = 2'b00;
        tick();

        // Single write of A5 to register 2 by requester 0
        bus_a.req = 2'b01; bus_a.addr = {2'd0, 2'd2}; bus_a.wdata = {8'h00, 8'hA5};
        tick();
        check("single_le",  bus_a.reg_le, 4'b0100);
        check("single_gnt", bus_a.gnt,    2'b01);
        tick();
        check("single_ack", bus_a.ack,    2'b01);
        tick();
        bus_a.req = 2'b00;
        tick();
        check("single_ackfall", bus_a.ack, 2'b00);
        check("single_bank2",   dbank[2],  8'hA5);

        // Contention from reset: each requester drops on ack and re-raises
        R = 1'b1;
        tick();
        R = 1'b0;
        bus_a.req = 2'b11; bus_a.addr = {2'd1, 2'd0}; bus_a.wdata = {8'h22, 8'h11};
        for (int c = 0; c < 40 && grant_log.size() < 6; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (bus_a.gnt[i]) grant_log.push_back(i);
                bus_a.req[i] = !bus_a.ack[i];
            end
        end
        check("rr_count", grant_log.size(), 6);
        for (int g = 0; g < grant_log.size(); g++) begin
            check($sformatf("rr_order%0d", g), grant_log[g], g % 2);
        end
        bus_a.req = 2'b00;
        repeat (3) tick();

        // Early drop by requester 1 in its LOAD cycle
        bus_a.req = 2'b10; bus_a.addr = {2'd3, 2'd0}; bus_a.wdata = {8'h5A, 8'h00};
        tick();
        check("early_gnt", bus_a.gnt, 2'b10);
        bus_a.req = 2'b00;
        ack_cycles = 0;
        repeat (3) begin
            tick();
            if (bus_a.ack[1]) ack_cycles++;
        end
        check("early_ack_len", ack_cycles, 1);
        check("early_bank3",   dbank[3],   8'h5A);

        // Reset asserted in LOAD; afterwards requester 0 must win (ptr back to 0)
        bus_a.req = 2'b01; bus_a.addr = {2'd2, 2'd1}; bus_a.wdata = {8'h99, 8'h77};
        tick();
        R = 1'b1;
        tick();
        check("rst_mid_le",  bus_a.reg_le, 4'b0000);
        check("rst_mid_ack", bus_a.ack,    2'b00);
        R = 1'b0;
        bus_a.req = 2'b11;
        tick();
        check("rst_mid_win", bus_a.gnt, 2'b01);
        check("rst_mid_bank1", dbank[1], 8'h77);
        bus_a.req = 2'b00;
        repeat (3) tick();

        // Out-of-range address on the 3-register instance
        bus_b.req = 2'b01; bus_b.addr = {2'd0, 2'd3}; bus_b.wdata = {8'h00, 8'h3C};
        tick_b();
        check("bad_err",   bus_b.err,    1'b1);
        check("bad_le",    bus_b.reg_le, 3'b000);
        check("bad_gnt",   bus_b.gnt,    2'b01);
        check("bad_d",     bus_b.reg_d,  8'h3C);
        tick_b();
        check("bad_errclr", bus_b.err,   1'b0);
        check("bad_ack",    bus_b.ack,   2'b01);
        check("bad_le2",    bus_b.reg_le, 3'b000);
        @(negedge clk);
        bus_b.req = 2'b00;
        tick_b();
        check("bad_ackfall", bus_b.ack,  2'b00);
        check("bad_busy",    bus_b.busy, 1'b0);
        @(negedge clk);
        bus_b.req = 2'b10; bus_b.addr = {2'd2, 2'd0}; bus_b.wdata = {8'hC3, 8'h00};
        tick_b();
        check("b_ok_le",  bus_b.reg_le, 3'b100);
        check("b_ok_err", bus_b.err,    1'b0);
        @(negedge clk);
        bus_b.req = 2'b00;

        // Randomised traffic, protocol-legal requesters, rare resets
        for (int c = 0; c < 3000; c++) begin
            R = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus_a.req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus_a.req[i] = 1'b1;
                        bus_a.addr[i*AW +: AW] = AW'($urandom_range(0, NREG - 1));
                        bus_a.wdata[i*W +: W]  = W'($urandom);
                    end
                end else if (bus_a.ack[i]) begin
                    if ($urandom_range(0, 1) == 0) bus_a.req[i] = 1'b0;
                end else if (bus_a.gnt[i]) begin
                    if ($urandom_range(0, 3) == 0) bus_a.req[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus_a.req[i] = 1'b0;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
